// File: rtl/parking_pkg.sv
// parking_pkg: shared states, seven-segment glyphs and default ticket codes for the car-park gates
package parking_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_TICKET, S_REJECT, S_OPEN, S_CLOSE, S_ALARM, S_GHOST
  } state_t;
  // Active-low segments, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [3:0] EXIT_CODE_DEF    = 4'b1001;
  localparam logic [3:0] SERVICE_CODE_DEF = 4'b1111;
endpackage

// File: rtl/parking_exit_gate_if.sv
// parking_exit_gate_if: ticket code valid/ready handshake between reader and gate controller
interface parking_exit_gate_if;
  logic       ticket_valid;
  logic       ticket_ready;
  logic [3:0] ticket_code;
  modport master (output ticket_valid, ticket_code, input ticket_ready);
  modport slave (input ticket_valid, ticket_code, output ticket_ready);
endinterface

// File: rtl/parking_seg_glyph.sv
// parking_seg_glyph: registered state-to-two-digit seven-segment decoder
module parking_seg_glyph
  import parking_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  state_t     i_state,
  output logic [6:0] o_hex_1,
  output logic [6:0] o_hex_2
);
  logic [13:0] w_pair;
  always_comb begin
    w_pair = {SEG_BLANK, SEG_BLANK};
    case (i_state)
      S_WAIT_TICKET: w_pair = {SEG_P, SEG_D};
      S_REJECT:      w_pair = {SEG_E, SEG_E};
      S_OPEN:        w_pair = {SEG_6, SEG_0};
      S_CLOSE:       w_pair = {SEG_C, SEG_BLANK};
      S_ALARM:       w_pair = {SEG_A, SEG_L};
      S_GHOST:       w_pair = {SEG_0, SEG_E};
      default:       w_pair = {SEG_BLANK, SEG_BLANK};
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {o_hex_1, o_hex_2} <= {SEG_BLANK, SEG_BLANK};
    else {o_hex_1, o_hex_2} <= w_pair;
endmodule

// File: rtl/parking_exit_gate.sv
// parking_exit_gate: exit barrier controller issuing a one-cycle depart pulse per confirmed exit
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter logic [3:0] EXIT_CODE     = EXIT_CODE_DEF,
  parameter logic [3:0] SERVICE_CODE  = SERVICE_CODE_DEF,
  parameter int         PAY_TIMEOUT   = 16,
  parameter int         OPEN_CYCLES   = 8,
  parameter int         REJECT_CYCLES = 4,
  parameter int         MAX_TRIES     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_sensor_approach,
  input  logic                 i_sensor_clear,
  input  logic [4:0]           i_occupancy,
  parking_exit_gate_if.slave   tkt,
  output logic                 o_barrier_open,
  output logic                 o_depart_pulse,
  output logic                 o_alarm,
  output logic                 o_green_led,
  output logic                 o_red_led,
  output logic [6:0]           o_hex_1,
  output logic [6:0]           o_hex_2
);
  // One timer serves every timed state, so size it for the longest interval
  localparam int TMAX = PAY_TIMEOUT > OPEN_CYCLES ?
                        (PAY_TIMEOUT > REJECT_CYCLES ? PAY_TIMEOUT : REJECT_CYCLES) :
                        (OPEN_CYCLES > REJECT_CYCLES ? OPEN_CYCLES : REJECT_CYCLES);
  localparam int TW  = $clog2(TMAX) + 1;
  localparam int TRW = $clog2(MAX_TRIES) + 1;
  state_t           r_state, w_next;
  logic [TW-1:0]    r_timer, w_timer_inc;
  logic [TRW-1:0]   r_tries, w_tries_inc;
  logic             r_ticket_ready, w_hs, w_exit_ok, w_service_ok, w_bad_ticket;
  assign tkt.ticket_ready = r_ticket_ready;
  assign w_hs         = tkt.ticket_valid && r_ticket_ready;
  assign w_exit_ok    = w_hs && tkt.ticket_code == EXIT_CODE;
  assign w_service_ok = w_hs && tkt.ticket_code == SERVICE_CODE;
  assign w_bad_ticket = w_hs && tkt.ticket_code != EXIT_CODE;
  assign w_timer_inc  = &r_timer ? r_timer : r_timer + 1'b1;
  assign w_tries_inc  = &r_tries ? r_tries : r_tries + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        w_next = !i_sensor_approach ? S_IDLE :
                              i_occupancy == '0 ? S_GHOST : S_WAIT_TICKET;
      S_WAIT_TICKET: w_next = w_exit_ok ? S_OPEN :
                              w_hs ? (w_tries_inc >= TRW'(MAX_TRIES) ? S_ALARM : S_REJECT) :
                              r_timer == TW'(PAY_TIMEOUT - 1) ? S_ALARM :
                              !i_sensor_approach ? S_IDLE : S_WAIT_TICKET;
      S_REJECT:      w_next = r_timer == TW'(REJECT_CYCLES - 1) ? S_WAIT_TICKET : S_REJECT;
      S_OPEN:        w_next = i_sensor_clear ? S_CLOSE :
                              r_timer == TW'(OPEN_CYCLES - 1) ? S_IDLE : S_OPEN;
      S_CLOSE:       w_next = !i_sensor_clear && !i_sensor_approach ? S_IDLE : S_CLOSE;
      S_ALARM:       w_next = w_service_ok ? S_IDLE : S_ALARM;
      S_GHOST:       w_next = i_sensor_approach ? S_GHOST : S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end
  // Outputs decode next state so they switch on the same edge as the state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_timer        <= '0;
      r_tries        <= '0;
      r_ticket_ready <= 1'b0;
      o_barrier_open <= 1'b0;
      o_depart_pulse <= 1'b0;
      o_alarm        <= 1'b0;
      o_green_led    <= 1'b0;
      o_red_led      <= 1'b0;
    end else begin
      r_timer        <= w_next != r_state ? '0 : w_timer_inc;
      r_tries        <= r_state == S_IDLE ? '0 :
                        r_state == S_WAIT_TICKET && w_bad_ticket ? w_tries_inc : r_tries;
      r_ticket_ready <= w_next == S_WAIT_TICKET || w_next == S_ALARM;
      o_barrier_open <= w_next == S_OPEN;
      o_depart_pulse <= r_state == S_OPEN && w_next == S_CLOSE && i_occupancy != '0;
      o_alarm        <= w_next == S_ALARM;
      o_green_led    <= w_next == S_OPEN && (r_state != S_OPEN || !o_green_led);
      o_red_led      <= w_next == S_REJECT ? (r_state != S_REJECT || !o_red_led) :
                        w_next == S_WAIT_TICKET || w_next == S_GHOST || w_next == S_ALARM;
    end
  parking_seg_glyph u_glyph (
    .clk     (clk),
    .reset_n (reset_n),
    .i_state (w_next),
    .o_hex_1 (o_hex_1),
    .o_hex_2 (o_hex_2)
  );
endmodule
